// File: rtl/mdu_pkg.sv
// ============================================================================
//  Module      : mdu_pkg
//  Description : Shared MD opcode encodings, default latencies and FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mdu_pkg;

   localparam logic [2:0] MD_MULT  = 3'b000;
   localparam logic [2:0] MD_MULTU = 3'b001;
   localparam logic [2:0] MD_DIV   = 3'b010;
   localparam logic [2:0] MD_DIVU  = 3'b011;
   localparam logic [2:0] MD_MTHI  = 3'b100;
   localparam logic [2:0] MD_MTLO  = 3'b101;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   // mult/multu/div/divu all have a clear top opcode bit
   function automatic logic is_arith(input logic [2:0] op);
      return (op[2] == 1'b0);
   endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit_if.sv
// ============================================================================
//  Module      : muldiv_unit_if
//  Description : Control/result bundle between E-stage control and the MDU.
//                Cancel exists only when MDU_CANCEL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface muldiv_unit_if;

   logic        Start;
   logic [2:0]  MDOp;
   logic [31:0] D1;
   logic [31:0] D2;
`ifdef MDU_CANCEL_EN
   logic        Cancel;
`endif
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

`ifdef MDU_CANCEL_EN
   modport master (output Start, MDOp, D1, D2, Cancel, input Busy, HI, LO);
   modport slave  (input Start, MDOp, D1, D2, Cancel, output Busy, HI, LO);
`else
   modport master (output Start, MDOp, D1, D2, input Busy, HI, LO);
   modport slave  (input Start, MDOp, D1, D2, output Busy, HI, LO);
`endif

endinterface

`default_nettype wire

// File: rtl/mdu_compute.sv
// ============================================================================
//  Module      : mdu_compute
//  Description : Combinational mult/div datapath producing {hi, lo}; holds the
//                current HI/LO on divide-by-zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_compute
   import mdu_pkg::*;
(
   input  wire logic [2:0]  i_md_op,
   input  wire logic [31:0] i_d1,
   input  wire logic [31:0] i_d2,
   input  wire logic [31:0] i_hi_cur,
   input  wire logic [31:0] i_lo_cur,
   output logic      [63:0] o_result
);

   logic        w_signed;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [63:0] w_a64;
   logic [63:0] w_b64;
   logic [63:0] w_prod;
   logic [31:0] w_mag_a;
   logic [31:0] w_mag_b;
   logic [31:0] w_div_b;
   logic [31:0] w_uq;
   logic [31:0] w_ur;
   logic [31:0] w_q;
   logic [31:0] w_r;

   always_comb begin
      w_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
      w_neg_a  = w_signed & i_d1[31];
      w_neg_b  = w_signed & i_d2[31];

      // Low 64 bits of the extended product are correct for both signednesses
      w_a64  = {{32{w_neg_a}}, i_d1};
      w_b64  = {{32{w_neg_b}}, i_d2};
      w_prod = w_a64 * w_b64;

      // Sign-magnitude division: 0x80000000 / -1 yields 0x80000000 rem 0 naturally
      w_mag_a = w_neg_a ? (32'd0 - i_d1) : i_d1;
      w_mag_b = w_neg_b ? (32'd0 - i_d2) : i_d2;
      w_div_b = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
      w_uq    = w_mag_a / w_div_b;
      w_ur    = w_mag_a % w_div_b;
      w_q     = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
      w_r     = w_neg_a ? (32'd0 - w_ur) : w_ur;

      o_result = {i_hi_cur, i_lo_cur};
      case (i_md_op)
         MD_MULT, MD_MULTU: o_result = w_prod;
         MD_DIV, MD_DIVU: begin
            if (i_d2 != 32'd0) begin
               o_result = {w_r, w_q};
            end
         end
         default: o_result = {i_hi_cur, i_lo_cur};
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
//  Module      : muldiv_unit
//  Description : EX-stage multiply/divide unit with fixed-latency sequencing and
//                architectural HI/LO. Optional Cancel via MDU_CANCEL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  wire logic     clk,
   input  wire logic     reset,
   muldiv_unit_if.slave  bus
);

   localparam int C_MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int C_CNT_W   = $clog2(C_MAX_CYC + 1);
   localparam logic [C_CNT_W-1:0] C_MULT_LOAD = C_CNT_W'(MULT_CYCLES);
   localparam logic [C_CNT_W-1:0] C_DIV_LOAD  = C_CNT_W'(DIV_CYCLES);
   localparam logic [C_CNT_W-1:0] C_ONE       = C_CNT_W'(1);

   mdu_state_e         state_q, state_d;
   logic [C_CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]        phi_q, phi_d;
   logic [31:0]        plo_q, plo_d;
   logic [31:0]        hi_q, hi_d;
   logic [31:0]        lo_q, lo_d;
   logic               w_accept;
   logic [63:0]        w_result;

   mdu_compute u_compute (
      .i_md_op  (bus.MDOp),
      .i_d1     (bus.D1),
      .i_d2     (bus.D2),
      .i_hi_cur (hi_q),
      .i_lo_cur (lo_q),
      .o_result (w_result)
   );

`ifdef MDU_CANCEL_EN
   assign w_accept = bus.Start & ~bus.Cancel;
`else
   assign w_accept = bus.Start;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      phi_d   = phi_q;
      plo_d   = plo_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               if (is_arith(bus.MDOp)) begin
                  phi_d   = w_result[63:32];
                  plo_d   = w_result[31:0];
                  cnt_d   = bus.MDOp[1] ? C_DIV_LOAD : C_MULT_LOAD;
                  state_d = ST_RUN;
               end else if (bus.MDOp == MD_MTHI) begin
                  hi_d = bus.D1;
               end else if (bus.MDOp == MD_MTLO) begin
                  lo_d = bus.D1;
               end
            end
         end
         ST_RUN: begin
            // Start (including mthi/mtlo) is deliberately ignored while running
            cnt_d = cnt_q - C_ONE;
            if (cnt_q <= C_ONE) begin
               cnt_d   = '0;
               hi_d    = phi_q;
               lo_d    = plo_q;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign bus.Busy = (state_q == ST_RUN);
   assign bus.HI   = hi_q;
   assign bus.LO   = lo_q;

endmodule

`default_nettype wire
